// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter for video fetch, CPU access and clear engine
//
// Purpose: shares one synchronous single-port VRAM between the video scanout
// fetch path and the CPU register path. Every cycle one access is issued.
// The CPU can be starved for at most STARVE_MAX cycles. Read data returns
// three cycles after the request cycle, together with a one-cycle rvalid.
//
// Optional feature: define VRAM_CLEAR_EN to build the clear engine. It fills
// VRAM_DEPTH locations with a latched byte. Without the macro, clr_busy is
// tied low and clr_start/clr_data are ignored.
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   vid_req/vid_addr -> vid_ack         video read request and issue pulse
//   vid_rdata/vid_rvalid                video read return
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   cpu request
//   cpu_ack                             cpu issue pulse
//   cpu_rdata/cpu_rvalid                cpu read return
//   mem_addr/mem_wdata/mem_we/mem_rdata VRAM macro interface
//   clr_start/clr_data -> clr_busy      clear engine control

module vram_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4,
    parameter int VRAM_DEPTH = 16384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_data,
    output logic              clr_busy
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_CPU  = 2'd2
    } tag_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic              grant_vid;
    logic              grant_cpu;
    logic              grant_clr;
    logic              cpu_forced;

    logic [3:0]        starve_q, starve_d;
    tag_e              tag1_q, tag1_d;
    tag_e              tag2_q;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              vid_ack_q, cpu_ack_q;
    logic [DATA_W-1:0] vid_rdata_q, cpu_rdata_q;
    logic              vid_rvalid_q, cpu_rvalid_q;

    logic              clr_busy_w;
    logic [ADDR_W-1:0] clr_addr_w;
    logic [DATA_W-1:0] clr_fill_w;

`ifdef VRAM_CLEAR_EN
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(VRAM_DEPTH - 1);

    logic              clr_busy_q, clr_busy_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] clr_fill_q, clr_fill_d;

    always_comb begin
        clr_busy_d = clr_busy_q;
        clr_cnt_d  = clr_cnt_q;
        clr_fill_d = clr_fill_q;
        if (!clr_busy_q && clr_start) begin
            clr_busy_d = 1'b1;
            clr_cnt_d  = '0;
            clr_fill_d = clr_data;
        end else if (grant_clr) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            // busy falls the cycle after the final location is granted
            if (clr_cnt_q == CLR_LAST) begin
                clr_busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_busy_q <= 1'b0;
            clr_cnt_q  <= '0;
            clr_fill_q <= '0;
        end else begin
            clr_busy_q <= clr_busy_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_fill_q <= clr_fill_d;
        end
    end

    assign clr_busy_w = clr_busy_q;
    assign clr_addr_w = clr_cnt_q;
    assign clr_fill_w = clr_fill_q;
`else
    logic unused_clr;
    assign unused_clr = ^{clr_start, clr_data};
    assign clr_busy_w = 1'b0;
    assign clr_addr_w = '0;
    assign clr_fill_w = '0;
`endif

    // Arbitration. The forced cpu win is masked while clearing so the cpu
    // is never acked during a sweep; the counter holds meanwhile.
    always_comb begin
        cpu_forced = cpu_req && (starve_q == STARVE_LIM) && !clr_busy_w;
        grant_cpu  = cpu_req && !clr_busy_w && (cpu_forced || !vid_req);
        grant_vid  = vid_req && !cpu_forced;
        grant_clr  = clr_busy_w && !vid_req;
    end

    always_comb begin
        starve_d    = starve_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        tag1_d      = TAG_NONE;

        if (grant_cpu) begin
            starve_d = '0;
        end else if (cpu_req && !clr_busy_w && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
        end

        if (grant_cpu) begin
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            mem_we_d    = cpu_we;
            tag1_d      = cpu_we ? TAG_NONE : TAG_CPU;
        end else if (grant_vid) begin
            mem_addr_d  = vid_addr;
            tag1_d      = TAG_VID;
        end else if (grant_clr) begin
            mem_addr_d  = clr_addr_w;
            mem_wdata_d = clr_fill_w;
            mem_we_d    = 1'b1;
        end
    end

    // tag1 tracks the access on mem_* now; tag2 tracks the one whose data
    // is on mem_rdata now, which is captured into the rdata registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q     <= '0;
            tag1_q       <= TAG_NONE;
            tag2_q       <= TAG_NONE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            vid_ack_q    <= 1'b0;
            cpu_ack_q    <= 1'b0;
            vid_rdata_q  <= '0;
            cpu_rdata_q  <= '0;
            vid_rvalid_q <= 1'b0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            starve_q     <= starve_d;
            tag1_q       <= tag1_d;
            tag2_q       <= tag1_q;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            vid_ack_q    <= grant_vid;
            cpu_ack_q    <= grant_cpu;
            vid_rvalid_q <= (tag2_q == TAG_VID);
            cpu_rvalid_q <= (tag2_q == TAG_CPU);
            if (tag2_q == TAG_VID) begin
                vid_rdata_q <= mem_rdata;
            end
            if (tag2_q == TAG_CPU) begin
                cpu_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign vid_ack    = vid_ack_q;
    assign cpu_ack    = cpu_ack_q;
    assign vid_rdata  = vid_rdata_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign vid_rvalid = vid_rvalid_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign clr_busy   = clr_busy_w;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port video RAM between two requesters: the scanout fetch path (video) and the CPU register-interface path (cpu).
- Sequences every RAM access, returns read data with a valid strobe, and bounds CPU starvation.
- Sits between the CPU bus-interface block, the video timing/fetch block and the VRAM macro.
- Optional built-in clear engine fills VRAM with a constant byte.

Parameters:
- ADDR_W, 14, VRAM address width.
- DATA_W, 8, VRAM data width.
- STARVE_MAX, 4, consecutive lost cpu arbitration cycles before cpu is forced to win; range 1..15.
- VRAM_DEPTH, 16384, number of locations swept by the clear engine.

Ports:
- clk  in  1  master clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- vid_req  in  1  video read request; hold with vid_addr until vid_ack
- vid_addr  in  ADDR_W  video read address
- vid_ack  out  1  one-cycle pulse: video request issued to RAM
- vid_rdata  out  DATA_W  video read data
- vid_rvalid  out  1  one-cycle pulse: vid_rdata valid
- cpu_req  in  1  cpu request; hold with cpu_we/addr/wdata until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  cpu address
- cpu_wdata  in  DATA_W  cpu write data
- cpu_ack  out  1  one-cycle pulse: cpu request issued to RAM
- cpu_rdata  out  DATA_W  cpu read data
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid (reads only)
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  DATA_W  RAM read data; synchronous RAM, valid the cycle after the address is presented
- clr_start  in  1  start clear sweep (ignored without VRAM_CLEAR_EN)
- clr_data  in  DATA_W  fill byte, latched on accepted clr_start
- clr_busy  out  1  clear sweep in progress

Behaviour:
- Reset: all outputs 0 (mem_addr, mem_wdata, mem_we, acks, rvalids, rdata, clr_busy); starvation counter, read-tag pipeline and clear counter cleared.
- Reset asserted mid-operation aborts any in-flight read (no rvalid is produced) and any clear sweep.
- One RAM access per clk cycle.
- Arbitration is evaluated combinationally from the requests in cycle N. The winner's address, data and write enable are registered onto mem_* in cycle N+1; its ack pulses in cycle N+1.
- mem_we is 0 in any cycle with no write grant.
- Read return: mem_rdata is valid in N+2 and registered into vid_rdata/cpu_rdata. The matching rvalid pulses in N+3. Total read latency is 3 cycles from the request cycle.
- A 2-stage tag pipeline (none / vid / cpu) steers the returned data. The rdata outputs hold their value between rvalid pulses.
- Priority order per cycle:
  1. cpu, if the starvation counter equals STARVE_MAX and cpu_req=1;
  2. video;
  3. clear engine (only while clr_busy);
  4. cpu, only when clr_busy=0.
- Starvation counter:
  - increments (saturating at STARVE_MAX) each cycle cpu_req=1 and cpu is not granted;
  - clears on a cpu grant;
  - holds while cpu_req=0 or clr_busy=1.
- A req still high in its ack cycle is a new request. The requester must present the next address in the ack cycle or drop req. Back-to-back grants to one port are allowed.
- cpu write: no rvalid; the RAM is written in N+1.
- Simultaneous vid_req and cpu_req with counter < STARVE_MAX: video wins, counter +1.

Optional Feature:
- Macro VRAM_CLEAR_EN.
- Defined:
  - clr_start=1 with clr_busy=0 latches clr_data, sets clr_busy=1 next cycle and clears the address counter to 0.
  - Each cycle the clear engine wins arbitration, it issues a write of the latched byte at the counter value, then increments the counter.
  - Video still preempts the clear engine. cpu is never acked while clr_busy=1.
  - The write to address VRAM_DEPTH-1 is the last one; clr_busy drops the cycle after it is issued.
  - clr_start while busy is ignored.
- Undefined: clr_busy tied 0; clr_start and clr_data ignored; no clear logic synthesised.

Test Plan:
- Video read only: vid_req with addr 0x0123, RAM preloaded 0x5A -> vid_ack at N+1, mem_addr=0x0123, vid_rvalid at N+3 with vid_rdata=0x5A.
- CPU write then read: write 0x3F00=0xA5, then read 0x3F00 -> mem_we=1 for exactly 1 cycle; cpu_rvalid 3 cycles after the read request, cpu_rdata=0xA5; no rvalid for the write.
- Contention with STARVE_MAX=4: vid_req and cpu_req held high continuously -> grants repeat as 4 video, 1 cpu; cpu_ack every 5th cycle.
- Interleaved reads: alternating vid/cpu reads back-to-back -> rvalids and rdata routed to the correct port with no cross-talk.
- Clear (VRAM_CLEAR_EN, VRAM_DEPTH=16): clr_start with clr_data=0x20, no video traffic -> 16 writes to addresses 0..15; clr_busy high for 16 cycles; concurrent cpu_req acked only after clr_busy falls.
- Reset mid-read and mid-clear: reset in the cycle after a vid_ack -> no vid_rvalid; clr_busy=0 and mem_we=0 the next cycle.
